// File: rtl/ex_writeback_if.sv
// Execute->writeback bus: execute beat in, register-file write out,
// PC redirect out and the NZP flag register. master = upstream/tb, slave = stage.
interface ex_writeback_if #(
    parameter int DATA_W = 12,
    parameter int REG_W  = 3
);
    logic              ex_valid;
    logic              ex_ready;
    logic [3:0]        ex_opcode;
    logic [REG_W-1:0]  ex_rd;
    logic [2:0]        ex_cond;
    logic [DATA_W-1:0] ex_result;
    logic              ex_zero;
    logic              ex_pos;
    logic              wb_valid;
    logic              wb_ready;
    logic [REG_W-1:0]  wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              redirect_valid;
    logic [DATA_W-1:0] redirect_pc;
    logic              flag_n;
    logic              flag_z;
    logic              flag_p;

    modport master (
        output ex_valid, ex_opcode, ex_rd, ex_cond, ex_result,
        output ex_zero, ex_pos, wb_ready,
        input  ex_ready, wb_valid, wb_addr, wb_data,
        input  redirect_valid, redirect_pc, flag_n, flag_z, flag_p
    );

    modport slave (
        input  ex_valid, ex_opcode, ex_rd, ex_cond, ex_result,
        input  ex_zero, ex_pos, wb_ready,
        output ex_ready, wb_valid, wb_addr, wb_data,
        output redirect_valid, redirect_pc, flag_n, flag_z, flag_p
    );
endinterface

// File: rtl/ex_writeback.sv
// Execute->writeback stage: registers ALU results into a valid/ready
// write port, keeps NZP flags, resolves branch/jump and squashes wrong-path beats.
// Ports: clk, rst_n (async active-low), bus (ex_writeback_if.slave).
module ex_writeback #(
    parameter int DATA_W      = 12,
    parameter int REG_W       = 3,
    parameter int FLUSH_DEPTH = 2
) (
    input logic            clk,
    input logic            rst_n,
    ex_writeback_if.slave  bus
);
    localparam int CNT_W = $clog2(FLUSH_DEPTH + 1);

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              wb_valid;
    logic [REG_W-1:0]  wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              redir_valid;
    logic [DATA_W-1:0] redir_pc;
    logic              fn;
    logic              fz;
    logic              fp;

    logic ready;
    logic accept;
    logic is_alu;
    logic is_br;
    logic is_jmp;
    logic taken;

    // FLUSH always accepts: discarded beats never need the write port.
    assign ready  = (state == FLUSH) | ~wb_valid | bus.wb_ready;
    assign accept = bus.ex_valid & ready;

    assign is_alu = bus.ex_opcode[3] | (bus.ex_opcode == 4'b0101);
    assign is_br  = (bus.ex_opcode == 4'b0011);
    assign is_jmp = (bus.ex_opcode == 4'b0010);
    assign taken  = is_jmp | (is_br & (|(bus.ex_cond & {fn, fz, fp})));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            cnt         <= '0;
            wb_valid    <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
            redir_valid <= 1'b0;
            redir_pc    <= '0;
            fn          <= 1'b0;
            fz          <= 1'b1;
            fp          <= 1'b0;
        end else begin
            redir_valid <= 1'b0;
            if (wb_valid && bus.wb_ready) begin
                wb_valid <= 1'b0;
            end
            if (accept) begin
                if (state == FLUSH) begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= RUN;
                    end
                end else begin
                    unique case (1'b1)
                        is_alu: begin
                            fz <= bus.ex_zero;
                            fp <= bus.ex_pos;
                            fn <= ~bus.ex_zero & ~bus.ex_pos;
                            if (bus.ex_rd != '0) begin
                                wb_valid <= 1'b1;
                                wb_addr  <= bus.ex_rd;
                                wb_data  <= bus.ex_result;
                            end
                        end
                        is_br, is_jmp: begin
                            if (taken) begin
                                redir_valid <= 1'b1;
                                redir_pc    <= bus.ex_result;
                                state       <= FLUSH;
                                cnt         <= CNT_W'(FLUSH_DEPTH);
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    assign bus.ex_ready       = ready;
    assign bus.wb_valid       = wb_valid;
    assign bus.wb_addr        = wb_addr;
    assign bus.wb_data        = wb_data;
    assign bus.redirect_valid = redir_valid;
    assign bus.redirect_pc    = redir_pc;
    assign bus.flag_n         = fn;
    assign bus.flag_z         = fz;
    assign bus.flag_p         = fp;
endmodule

// File: tb/tb_ex_writeback.sv
// Directed-vector bench for ex_writeback.
// Drives beats on the falling edge and checks outputs on the falling edge.
module tb_ex_writeback;
    logic clk;
    logic rst_n;
    int   errs;
    int   checks;

    logic [11:0] wlog[$];

    ex_writeback_if #(.DATA_W(12), .REG_W(3)) bus ();

    ex_writeback #(
        .DATA_W(12),
        .REG_W(3),
        .FLUSH_DEPTH(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && bus.wb_valid && bus.wb_ready) begin
            wlog.push_back(bus.wb_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.ex_valid = 1'b0;
        @(negedge clk);
    endtask

    // Called on a negedge; returns on the negedge after acceptance.
    task automatic send(input logic [3:0] op, input logic [2:0] rd,
                        input logic [2:0] cond, input logic [11:0] res,
                        input logic z, input logic p);
        int n;
        bus.ex_valid  = 1'b1;
        bus.ex_opcode = op;
        bus.ex_rd     = rd;
        bus.ex_cond   = cond;
        bus.ex_result = res;
        bus.ex_zero   = z;
        bus.ex_pos    = p;
        n = 0;
        while (!bus.ex_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            chk("send_timeout", 32'd1, 32'd0);
        end else begin
            @(negedge clk);
        end
        bus.ex_valid = 1'b0;
    endtask

    task automatic chk_flags(input string tag, input logic n,
                             input logic z, input logic p);
        chk(tag, {29'd0, bus.flag_n, bus.flag_z, bus.flag_p}, {29'd0, n, z, p});
    endtask

    initial begin
        errs   = 0;
        checks = 0;
        rst_n  = 1'b0;
        bus.ex_valid  = 1'b0;
        bus.ex_opcode = 4'h0;
        bus.ex_rd     = 3'd0;
        bus.ex_cond   = 3'd0;
        bus.ex_result = 12'h000;
        bus.ex_zero   = 1'b0;
        bus.ex_pos    = 1'b0;
        bus.wb_ready  = 1'b1;

        @(negedge clk);
        @(negedge clk);
        chk("rst_wb_valid", bus.wb_valid, 0);
        chk("rst_wb_addr", bus.wb_addr, 0);
        chk("rst_wb_data", bus.wb_data, 0);
        chk("rst_redir", bus.redirect_valid, 0);
        chk("rst_pc", bus.redirect_pc, 0);
        chk_flags("rst_flags", 0, 1, 0);
        chk("rst_ready", bus.ex_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD rd=3 0x005, positive
        send(4'b1000, 3'd3, 3'd0, 12'h005, 1'b0, 1'b1);
        chk("add_valid", bus.wb_valid, 1);
        chk("add_addr", bus.wb_addr, 3);
        chk("add_data", bus.wb_data, 12'h005);
        chk_flags("add_flags", 0, 0, 1);
        idle();
        chk("add_drain", bus.wb_valid, 0);

        // Backpressure: two writes, neither lost nor duplicated
        wlog.delete();
        bus.wb_ready = 1'b0;
        send(4'b1000, 3'd1, 3'd0, 12'h111, 1'b0, 1'b1);
        chk("bp_data1", bus.wb_data, 12'h111);
        bus.ex_valid  = 1'b1;
        bus.ex_rd     = 3'd2;
        bus.ex_result = 12'h222;
        #1;
        chk("bp_not_ready", bus.ex_ready, 0);
        @(negedge clk);
        @(negedge clk);
        chk("bp_hold_data", bus.wb_data, 12'h111);
        chk("bp_hold_addr", bus.wb_addr, 1);
        bus.wb_ready = 1'b1;
        @(negedge clk);
        bus.ex_valid = 1'b0;
        chk("bp_data2", bus.wb_data, 12'h222);
        chk("bp_addr2", bus.wb_addr, 2);
        idle();
        idle();
        chk("bp_count", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("bp_order0", wlog[0], 12'h111);
            chk("bp_order1", wlog[1], 12'h222);
        end

        // SUB -> zero, branch on z taken back-to-back
        send(4'b1001, 3'd4, 3'd0, 12'h000, 1'b1, 1'b0);
        chk_flags("sub_flags", 0, 1, 0);
        send(4'b0011, 3'd0, 3'b010, 12'h040, 1'b0, 1'b0);
        chk("br_redir", bus.redirect_valid, 1);
        chk("br_pc", bus.redirect_pc, 12'h040);
        chk("br_no_wb", bus.wb_valid, 0);
        send(4'b1000, 3'd5, 3'd0, 12'h055, 1'b0, 1'b1);
        chk("fl1_pulse_end", bus.redirect_valid, 0);
        chk("fl1_no_wb", bus.wb_valid, 0);
        chk_flags("fl1_flags", 0, 1, 0);
        idle();
        idle();
        send(4'b1000, 3'd6, 3'd0, 12'h066, 1'b0, 1'b1);
        chk("fl2_no_wb", bus.wb_valid, 0);
        chk_flags("fl2_flags", 0, 1, 0);
        send(4'b1000, 3'd7, 3'd0, 12'h077, 1'b0, 1'b1);
        chk("fl3_wb", bus.wb_valid, 1);
        chk("fl3_data", bus.wb_data, 12'h077);
        chk_flags("fl3_flags", 0, 0, 1);

        // Branch not taken
        send(4'b1000, 3'd1, 3'd0, 12'h000, 1'b1, 1'b0);
        send(4'b0011, 3'd0, 3'b001, 12'h100, 1'b0, 1'b0);
        chk("nt_redir", bus.redirect_valid, 0);
        send(4'b1000, 3'd2, 3'd0, 12'h0AA, 1'b0, 1'b1);
        chk("nt_wb", bus.wb_valid, 1);
        chk("nt_data", bus.wb_data, 12'h0AA);

        // Jump, one discarded beat, then reset mid-flush
        send(4'b0010, 3'd0, 3'd0, 12'h7FF, 1'b0, 1'b0);
        chk("jmp_redir", bus.redirect_valid, 1);
        chk("jmp_pc", bus.redirect_pc, 12'h7FF);
        send(4'b1000, 3'd3, 3'd0, 12'h033, 1'b1, 1'b0);
        chk("jmp_discard", bus.wb_valid, 0);
        chk_flags("jmp_flags", 0, 0, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wb", bus.wb_valid, 0);
        chk_flags("mid_rst_flags", 0, 1, 0);
        chk("mid_rst_pc", bus.redirect_pc, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(4'b1000, 3'd5, 3'd0, 12'h0BB, 1'b0, 1'b1);
        chk("post_rst_wb", bus.wb_valid, 1);
        chk("post_rst_data", bus.wb_data, 12'h0BB);

        // rd=0: no write but flags update (negative)
        send(4'b0101, 3'd0, 3'd0, 12'hABC, 1'b0, 1'b0);
        chk("rd0_no_wb", bus.wb_valid, 0);
        chk_flags("rd0_flags", 1, 0, 0);

        // NOP consumed with no effect
        send(4'b0000, 3'd4, 3'd0, 12'h123, 1'b1, 1'b0);
        chk("nop_no_wb", bus.wb_valid, 0);
        chk_flags("nop_flags", 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
